// File: rtl/ula_arbiter_ctrl.sv
// ula_arbiter_ctrl: shares one 8-bit ULA datapath between two requesters.
// Arbitrates, latches the winning op/operands, executes in a registered
// stage and returns a one-cycle response tagged with the owning requester.
// Accept at T -> rsp_valid at T+2; at most one op every 3 cycles.
// Build option: define ULA_ARB_FIXED_PRIO_EN for fixed priority (req 0
// wins ties); otherwise round-robin on the last accepted requester.
module ula_arbiter_ctrl #(
  parameter int unsigned W   = 8,
  parameter int unsigned OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid_i,
  output logic [1:0]     req_ready_o,
  input  logic [OPW-1:0] req0_op_i,
  input  logic [W-1:0]   req0_a_i,
  input  logic [W-1:0]   req0_b_i,
  input  logic [OPW-1:0] req1_op_i,
  input  logic [W-1:0]   req1_a_i,
  input  logic [W-1:0]   req1_b_i,
  output logic [1:0]     rsp_valid_o,
  output logic [W-1:0]   rsp_data_o,
  output logic           rsp_carry_o,
  output logic           busy_o
);

  localparam logic [OPW-1:0] OP_AND = OPW'(0);
  localparam logic [OPW-1:0] OP_OR  = OPW'(1);
  localparam logic [OPW-1:0] OP_XOR = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4);
  localparam logic [OPW-1:0] OP_NOT = OPW'(5);
  localparam logic [OPW-1:0] OP_SHL = OPW'(6);
  localparam logic [OPW-1:0] OP_SHR = OPW'(7);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e         state_q;
  logic           grant_q;
  logic [OPW-1:0] op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [1:0]     rsp_valid_q;
  logic [W-1:0]   rsp_data_q;
  logic           rsp_carry_q;
  logic           busy_q;
`ifndef ULA_ARB_FIXED_PRIO_EN
  logic           last_grant_q;
`endif

  logic           grant_c;
  logic           accept_c;
  logic [OPW-1:0] sel_op_c;
  logic [W-1:0]   sel_a_c;
  logic [W-1:0]   sel_b_c;
  logic [W-1:0]   alu_res_c;
  logic           alu_carry_c;
  logic [W:0]     alu_ext_c;

  // Arbitration winner among the currently valid requesters (index 0 or 1)
  always_comb begin
    grant_c = 1'b0;
`ifdef ULA_ARB_FIXED_PRIO_EN
    grant_c = ~req_valid_i[0];
`else
    if (&req_valid_i) begin
      grant_c = ~last_grant_q;
    end else begin
      grant_c = ~req_valid_i[0];
    end
`endif
  end

  // Accept only from IDLE, never during reset, never to a non-valid requester
  assign accept_c    = (state_q == S_IDLE) && (|req_valid_i) && !rst;
  assign req_ready_o = accept_c ? (grant_c ? 2'b10 : 2'b01) : 2'b00;

  // Operand mux selecting the winner's request for capture
  always_comb begin
    sel_op_c = req0_op_i;
    sel_a_c  = req0_a_i;
    sel_b_c  = req0_b_i;
    if (grant_c) begin
      sel_op_c = req1_op_i;
      sel_a_c  = req1_a_i;
      sel_b_c  = req1_b_i;
    end
  end

  // ULA datapath over the captured operands
  always_comb begin
    alu_res_c   = '0;
    alu_carry_c = 1'b0;
    alu_ext_c   = '0;
    case (op_q)
      OP_AND: alu_res_c = a_q & b_q;
      OP_OR:  alu_res_c = a_q | b_q;
      OP_XOR: alu_res_c = a_q ^ b_q;
      OP_ADD: begin
        alu_ext_c   = {1'b0, a_q} + {1'b0, b_q};
        alu_res_c   = alu_ext_c[W-1:0];
        alu_carry_c = alu_ext_c[W];
      end
      OP_SUB: begin
        // MSB of the extended difference is the borrow; carry means no borrow
        alu_ext_c   = {1'b0, a_q} - {1'b0, b_q};
        alu_res_c   = alu_ext_c[W-1:0];
        alu_carry_c = ~alu_ext_c[W];
      end
      OP_NOT: alu_res_c = ~a_q;
      OP_SHL: begin
        alu_res_c   = {a_q[W-2:0], 1'b0};
        alu_carry_c = a_q[W-1];
      end
      OP_SHR: begin
        alu_res_c   = {1'b0, a_q[W-1:1]};
        alu_carry_c = a_q[0];
      end
      default: begin
        alu_res_c   = '0;
        alu_carry_c = 1'b0;
      end
    endcase
  end

  // Control FSM with registered response, busy and round-robin history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifndef ULA_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      rsp_valid_q <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            grant_q      <= grant_c;
            op_q         <= sel_op_c;
            a_q          <= sel_a_c;
            b_q          <= sel_b_c;
            busy_q       <= 1'b1;
            state_q      <= S_EXEC;
`ifndef ULA_ARB_FIXED_PRIO_EN
            last_grant_q <= grant_c;
`endif
          end
        end
        S_EXEC: begin
          rsp_data_q  <= alu_res_c;
          rsp_carry_q <= alu_carry_c;
          rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_carry_o = rsp_carry_q;
  assign busy_o      = busy_q;

endmodule
